ita_output_controller: RTL and testbench

Drain stage that sits directly downstream of the requantizer FIFO. It pops packed requantized output words from a first-word-fall-through FIFO and registers them into a valid/ready output stream toward the output memory streamer. It counts the words of each output tile, delivers exactly the programmed number of words, and reports busy, word index and a tile-done pulse to the ITA controller.

---
 rtl/ita_output_controller.sv | 112 +++++++++++
 tb/tb_ita_output_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ita_output_controller.sv
// rtl/ita_output_controller.sv - drains requantizer FIFO words into a registered valid/ready output stream per tile
module ita_output_controller #(
    parameter int unsigned DW    = 128,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] tile_len_i,
    input  logic             fifo_empty_i,
    input  logic [DW-1:0]    fifo_data_i,
    output logic             pop_from_fifo_o,
    output logic [DW-1:0]    oup_data_o,
    output logic             oup_valid_o,
    input  logic             oup_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] word_idx_o,
    output logic             tile_done_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, pop_cnt_q, acc_cnt_q;
    logic [DW-1:0]    data_q;
    logic             valid_q;
    logic             done_q, done_d;
    logic             acc, slot_free, pop, start_ok;

    assign acc       = valid_q & oup_ready_i;
    assign slot_free = ~valid_q | oup_ready_i;
    assign start_ok  = (state_q == IDLE) & start_i;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (tile_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                pop = ~fifo_empty_i & slot_free & (pop_cnt_q < len_q);
                if (pop && (pop_cnt_q + CNT_W'(1) == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last accept always lands here: in RUN fewer than len_q words have been popped.
                if (acc && (acc_cnt_q + CNT_W'(1) == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q     <= '0;
            pop_cnt_q <= '0;
            acc_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_d;
            if (start_ok) begin
                len_q     <= tile_len_i;
                pop_cnt_q <= '0;
                acc_cnt_q <= '0;
            end else begin
                if (pop) pop_cnt_q <= pop_cnt_q + CNT_W'(1);
                if (acc) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
            // A pop refills the slot in the same cycle it is accepted, so there is no bubble.
            if (pop) begin
                data_q  <= fifo_data_i;
                valid_q <= 1'b1;
            end else if (acc) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign pop_from_fifo_o = pop;
    assign oup_data_o      = data_q;
    assign oup_valid_o     = valid_q;
    assign busy_o          = (state_q != IDLE);
    assign word_idx_o      = acc_cnt_q;
    assign tile_done_o     = done_q;

endmodule

// File: tb/tb_ita_output_controller.sv
// tb/tb_ita_output_controller.sv - directed scoreboard bench for ita_output_controller
module tb_ita_output_controller;

    localparam int unsigned DW    = 128;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_ni;
    logic             start_i;
    logic [CNT_W-1:0] tile_len_i;
    logic             fifo_empty_i;
    logic [DW-1:0]    fifo_data_i;
    logic             pop_from_fifo_o;
    logic [DW-1:0]    oup_data_o;
    logic             oup_valid_o;
    logic             oup_ready_i;
    logic             busy_o;
    logic [CNT_W-1:0] word_idx_o;
    logic             tile_done_o;

    ita_output_controller #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .tile_len_i      (tile_len_i),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_data_i     (fifo_data_i),
        .pop_from_fifo_o (pop_from_fifo_o),
        .oup_data_o      (oup_data_o),
        .oup_valid_o     (oup_valid_o),
        .oup_ready_i     (oup_ready_i),
        .busy_o          (busy_o),
        .word_idx_o      (word_idx_o),
        .tile_done_o     (tile_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    fq[$];
    logic [DW-1:0]    sb[$];
    int               errors = 0;
    int               checks = 0;
    int               pops   = 0;
    int               accs   = 0;
    logic             s_pop, s_valid, s_done, s_busy;
    logic [DW-1:0]    s_data;
    logic [CNT_W-1:0] s_idx;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        sb.push_back(w);
        refresh();
    endtask

    task automatic step();
        #1;
        s_pop   = pop_from_fifo_o;
        s_valid = oup_valid_o;
        s_data  = oup_data_o;
        s_done  = tile_done_o;
        s_busy  = busy_o;
        s_idx   = word_idx_o;
        if (s_pop) chk("pop_when_empty", fifo_empty_i, 0);
        if (s_valid && oup_ready_i) begin
            accs++;
            if (sb.size() > 0) chk("out_data", s_data, sb.pop_front());
            else chk("sb_underflow", sb.size(), 1);
        end
        @(posedge clk);
        #1;
        if (s_pop) begin
            pops++;
            void'(fq.pop_front());
        end
        refresh();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!s_done && n < budget);
        chk("tile_done_seen", s_done, 1);
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        tile_len_i  = '0;
        oup_ready_i = 1'b1;
        refresh();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", pop_from_fifo_o, 0);
        chk("rst_data", oup_data_o, 0);
        chk("rst_valid", oup_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_idx", word_idx_o, 0);
        chk("rst_done", tile_done_o, 0);
        rst_ni = 1'b1;

        // Streaming
        for (int i = 1; i <= 4; i++) push(DW'(i));
        tile_len_i = 4;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        chk("t1_busy_start_cycle", s_busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_pop", s_pop, 1);
            chk("t1_busy", s_busy, 1);
        end
        step();
        chk("t1_drain_pop", s_pop, 0);
        chk("t1_drain_valid", s_valid, 1);
        step();
        chk("t1_done", s_done, 1);
        chk("t1_busy_end", s_busy, 0);
        chk("t1_idx", s_idx, 4);
        step();
        chk("t1_done_single", s_done, 0);
        chk("t1_fifo_left", fq.size(), 0);

        // Backpressure
        oup_ready_i = 1'b0;
        pops = 0;
        push(128'h11); push(128'h12); push(128'h13);
        tile_len_i = 3;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("t2_first_pop", s_pop, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_stall_pop", s_pop, 0);
            chk("t2_hold_valid", s_valid, 1);
            chk("t2_hold_data", s_data, 128'h11);
        end
        chk("t2_pops_before_release", pops, 1);
        oup_ready_i = 1'b1;
        wait_done(20);
        chk("t2_idx", s_idx, 3);
        chk("t2_pops", pops, 3);

        // Starved FIFO
        pops = 0;
        accs = 0;
        push(128'h21);
        tile_len_i = 2;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("t3_pop1", s_pop, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_starve_pop", s_pop, 0);
            chk("t3_gap_valid", s_valid, 0);
            chk("t3_early_done", s_done, 0);
        end
        push(128'h22);
        wait_done(20);
        chk("t3_accs", accs, 2);
        chk("t3_pops", pops, 2);

        // Over-supply, then zero length
        pops = 0;
        for (int i = 1; i <= 5; i++) push(DW'(8'h30 + i));
        tile_len_i = 3;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        wait_done(20);
        chk("t4_pops", pops, 3);
        chk("t4_fifo_left", fq.size(), 2);
        tile_len_i = 0;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("t4_zero_done", s_done, 1);
        chk("t4_zero_busy", s_busy, 0);
        chk("t4_zero_pop", s_pop, 0);
        chk("t4_zero_idx", s_idx, 0);
        step();
        chk("t4_zero_done_single", s_done, 0);
        chk("t4_zero_fifo_left", fq.size(), 2);

        // Ignored start mid-run
        pops = 0;
        push(128'h41); push(128'h42);
        tile_len_i = 4;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        start_i    = 1'b1;
        tile_len_i = 7;
        step();
        start_i    = 1'b0;
        tile_len_i = 0;
        wait_done(20);
        chk("t5_idx", s_idx, 4);
        chk("t5_pops", pops, 4);
        chk("t5_fifo_left", fq.size(), 0);
        step();
        chk("t5_idle_busy", s_busy, 0);

        // Reset mid-tile
        oup_ready_i = 1'b0;
        push(128'h51); push(128'h52);
        tile_len_i = 2;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        step();
        chk("t6_valid_before_rst", oup_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_pop", pop_from_fifo_o, 0);
        chk("t6_rst_data", oup_data_o, 0);
        chk("t6_rst_valid", oup_valid_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        chk("t6_rst_idx", word_idx_o, 0);
        chk("t6_rst_done", tile_done_o, 0);
        fq.delete();
        sb.delete();
        refresh();
        @(negedge clk);
        rst_ni      = 1'b1;
        oup_ready_i = 1'b1;
        pops = 0;
        push(128'h61); push(128'h62); push(128'h63);
        tile_len_i = 3;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        wait_done(20);
        chk("t6_idx", s_idx, 3);
        chk("t6_pops", pops, 3);
        chk("t6_sb_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
